// File: rtl/ifft64_pkg.sv
// rtl/ifft64_pkg.sv - shared constants and state encoding for the 64-point IFFT sequencer
package ifft64_pkg;

    localparam int FFT_N       = 64;
    localparam int N_STAGES    = 3;
    localparam int N_BFLY      = 16;
    localparam int TW_PER_BFLY = 3;
    localparam int ADDR_W      = $clog2(FFT_N);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_FINISH = 2'd3
    } state_t;

endpackage

// File: rtl/ifft64_wb_delay.sv
// rtl/ifft64_wb_delay.sv - valid+address delay line feeding the in-place write-back
//
// Ports:
//   clk        clock
//   clr        synchronous clear of every stage (reset or abort)
//   in_valid   read strobe entering the pipe
//   in_addr    read address entering the pipe
//   out_valid  write strobe, in_valid delayed LAT cycles
//   out_addr   write address, in_addr delayed LAT cycles
module ifft64_wb_delay #(
    parameter int LAT = 6,
    parameter int W   = 6
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         in_valid,
    input  logic [W-1:0] in_addr,
    output logic         out_valid,
    output logic [W-1:0] out_addr
);

    logic [LAT-1:0] v_pipe;
    logic [W-1:0]   a_pipe [LAT];

    always_ff @(posedge clk) begin
        if (clr) begin
            v_pipe <= '0;
            for (int i = 0; i < LAT; i++) begin
                a_pipe[i] <= '0;
            end
        end else begin
            v_pipe    <= {v_pipe[LAT-2:0], in_valid};
            a_pipe[0] <= in_addr;
            for (int i = 1; i < LAT; i++) begin
                a_pipe[i] <= a_pipe[i-1];
            end
        end
    end

    assign out_valid = v_pipe[LAT-1];
    assign out_addr  = a_pipe[LAT-1];

endmodule

// File: rtl/ifft64_ctrl.sv
// rtl/ifft64_ctrl.sv - sequencer for the 64-point radix-4 in-place IFFT engine
//
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   start             begin a transform (honoured only in IDLE)
//   abort             return to IDLE at once and flush pending write-backs
//   busy, done        transform in progress / one-cycle completion pulse
//   stage, bf_phase   current stage 0..2 and butterfly input index j
//   rd_en, rd_addr    data RAM read strobe and address
//   tw_en, tw_addr    twiddle ROM enable and address
//   wr_en, wr_addr    data RAM write-back strobe and address
module ifft64_ctrl
    import ifft64_pkg::*;
#(
    parameter int BF_LAT = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic [1:0]        stage,
    output logic [1:0]        bf_phase,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              tw_en,
    output logic [ADDR_W-1:0] tw_addr,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr
);

    localparam logic [3:0] DRAIN_LAST = 4'(BF_LAT - 1);
    localparam logic [1:0] STAGE_LAST = 2'(N_STAGES - 1);
    localparam logic [3:0] BFLY_LAST  = 4'(N_BFLY - 1);

    state_t      state_q, state_n;
    logic [1:0]  stage_q, stage_n;
    logic [3:0]  b_q, b_n;
    logic [1:0]  j_q, j_n;
    logic [3:0]  dcnt_q, dcnt_n;

    logic              busy_d, done_d, rd_en_d, tw_en_d;
    logic [1:0]        bf_phase_d;
    logic [ADDR_W-1:0] rd_addr_d, tw_addr_d;

    // Address arithmetic scratch: lq = log2(quarter), ks = 2*stage.
    logic [2:0]        lq, ks;
    logic [ADDR_W-1:0] b6, qmask, n6, g6, base6, k6;
    logic [1:0]        jm1;

    // State register; outputs are registered from the next-state decode so
    // they line up with the cycle the FSM is actually in.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            stage_q  <= '0;
            b_q      <= '0;
            j_q      <= '0;
            dcnt_q   <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            bf_phase <= '0;
            rd_en    <= 1'b0;
            rd_addr  <= '0;
            tw_en    <= 1'b0;
            tw_addr  <= '0;
        end else begin
            state_q  <= state_n;
            stage_q  <= stage_n;
            b_q      <= b_n;
            j_q      <= j_n;
            dcnt_q   <= dcnt_n;
            busy     <= busy_d;
            done     <= done_d;
            bf_phase <= bf_phase_d;
            rd_en    <= rd_en_d;
            rd_addr  <= rd_addr_d;
            tw_en    <= tw_en_d;
            tw_addr  <= tw_addr_d;
        end
    end

    assign stage = stage_q;

    // Next-state and counter logic.
    always_comb begin
        state_n = state_q;
        stage_n = stage_q;
        b_n     = b_q;
        j_n     = j_q;
        dcnt_n  = dcnt_q;
        if (abort) begin
            state_n = ST_IDLE;
            stage_n = '0;
            b_n     = '0;
            j_n     = '0;
            dcnt_n  = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_n = ST_RUN;
                        stage_n = '0;
                        b_n     = '0;
                        j_n     = '0;
                    end
                end
                ST_RUN: begin
                    if (j_q == 2'd3) begin
                        j_n = '0;
                        if (b_q == BFLY_LAST) begin
                            state_n = ST_DRAIN;
                            dcnt_n  = '0;
                        end else begin
                            b_n = b_q + 4'd1;
                        end
                    end else begin
                        j_n = j_q + 2'd1;
                    end
                end
                ST_DRAIN: begin
                    // Hold off the next stage until the last write-back has
                    // issued, since the transform is computed in place.
                    if (dcnt_q == DRAIN_LAST) begin
                        dcnt_n = '0;
                        b_n    = '0;
                        j_n    = '0;
                        if (stage_q == STAGE_LAST) begin
                            state_n = ST_FINISH;
                        end else begin
                            state_n = ST_RUN;
                            stage_n = stage_q + 2'd1;
                        end
                    end else begin
                        dcnt_n = dcnt_q + 4'd1;
                    end
                end
                ST_FINISH: begin
                    state_n = ST_IDLE;
                    stage_n = '0;
                end
                default: state_n = ST_IDLE;
            endcase
        end
    end

    // Output decode of the next state: read/twiddle addresses by shift/mask.
    always_comb begin
        case (stage_n)
            2'd0:    begin lq = 3'd4; ks = 3'd0; end
            2'd1:    begin lq = 3'd2; ks = 3'd2; end
            default: begin lq = 3'd0; ks = 3'd4; end
        endcase
        b6    = {2'b00, b_n};
        qmask = (6'd1 << lq) - 6'd1;
        n6    = b6 & qmask;
        g6    = b6 >> lq;
        base6 = (g6 << (lq + 3'd2)) + n6;
        k6    = n6 << ks;
        jm1   = j_n - 2'd1;

        rd_en_d    = (state_n == ST_RUN);
        bf_phase_d = rd_en_d ? j_n : 2'd0;
        rd_addr_d  = rd_en_d ? (base6 + ({4'b0000, j_n} << lq)) : '0;
        // j=0 is the untwiddled leg; legs 1..3 use W^((j)k) stored at 3k+j-1.
        tw_en_d    = rd_en_d && (j_n != 2'd0);
        tw_addr_d  = tw_en_d ? ((k6 << 1) + k6 + {4'b0000, jm1}) : '0;
        busy_d     = (state_n != ST_IDLE);
        done_d     = (state_n == ST_FINISH);
    end

    ifft64_wb_delay #(
        .LAT (BF_LAT),
        .W   (ADDR_W)
    ) u_wb_delay (
        .clk       (clk),
        .clr       (!rst_n || abort),
        .in_valid  (rd_en),
        .in_addr   (rd_addr),
        .out_valid (wr_en),
        .out_addr  (wr_addr)
    );

endmodule

// File: tb/tb_ifft64_ctrl.sv
// tb/tb_ifft64_ctrl.sv - directed self-checking bench for ifft64_ctrl
module tb_ifft64_ctrl;

    logic       clk = 1'b0;
    logic       rst_n, start, abort;
    logic       busy, done, rd_en, tw_en, wr_en;
    logic [1:0] stage, bf_phase;
    logic [5:0] rd_addr, tw_addr, wr_addr;

    int n_assert = 0;
    int n_fail   = 0;

    localparam int NREC = 230;
    logic       r_busy [NREC];
    logic       r_done [NREC];
    logic       r_rd   [NREC];
    logic       r_tw   [NREC];
    logic       r_wr   [NREC];
    logic [1:0] r_stg  [NREC];
    logic [1:0] r_ph   [NREC];
    logic [5:0] r_ra   [NREC];
    logic [5:0] r_ta   [NREC];
    logic [5:0] r_wa   [NREC];

    always #5 clk = ~clk;

    ifft64_ctrl #(.BF_LAT(6)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .abort    (abort),
        .busy     (busy),
        .done     (done),
        .stage    (stage),
        .bf_phase (bf_phase),
        .rd_en    (rd_en),
        .rd_addr  (rd_addr),
        .tw_en    (tw_en),
        .tw_addr  (tw_addr),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_done"}, 32'(done), 0);
        chk({tag, "_rd"},   32'({rd_en, rd_addr, bf_phase, stage}), 0);
        chk({tag, "_tw"},   32'({tw_en, tw_addr}), 0);
        chk({tag, "_wr"},   32'({wr_en, wr_addr}), 0);
    endtask

    initial begin
        int c_busy, c_done, c_rd, c_wr, c_tw, wr_bad, cnt;

        rst_n = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        step();
        step();
        chk_all_zero("reset");
        rst_n = 1'b1;
        step();
        chk("idle_no_start_busy", 32'(busy), 0);

        // Full transform, recording every cycle from the first RUN cycle.
        start = 1'b1;
        step();
        start = 1'b0;
        for (int c = 0; c < NREC; c++) begin
            r_busy[c] = busy;  r_done[c] = done;  r_rd[c] = rd_en;
            r_tw[c]   = tw_en; r_wr[c]   = wr_en; r_stg[c] = stage;
            r_ph[c]   = bf_phase;
            r_ra[c]   = rd_addr; r_ta[c] = tw_addr; r_wa[c] = wr_addr;
            step();
        end

        c_busy = 0; c_done = 0; c_rd = 0; c_wr = 0; c_tw = 0; wr_bad = 0;
        for (int c = 0; c < NREC; c++) begin
            c_busy += int'(r_busy[c]);
            c_done += int'(r_done[c]);
            c_rd   += int'(r_rd[c]);
            c_wr   += int'(r_wr[c]);
            c_tw   += int'(r_tw[c]);
            if (c < 6) begin
                if (r_wr[c] !== 1'b0) wr_bad++;
            end else begin
                if (r_wr[c] !== r_rd[c-6]) wr_bad++;
                else if (r_rd[c-6] && (r_wa[c] !== r_ra[c-6])) wr_bad++;
            end
        end
        chk("busy_cycles", c_busy, 211);
        chk("busy_first", 32'(r_busy[0]), 1);
        chk("busy_last", 32'(r_busy[210]), 1);
        chk("busy_after", 32'(r_busy[211]), 0);
        chk("done_count", c_done, 1);
        chk("done_last_busy", 32'(r_done[210]), 1);
        chk("rd_count", c_rd, 192);
        chk("wr_count", c_wr, 192);
        chk("tw_count", c_tw, 144);
        chk("wr_delay_mismatches", wr_bad, 0);

        chk("s0b0_rd", 32'({r_ra[0], r_ra[1], r_ra[2], r_ra[3]}), 32'({6'd0, 6'd16, 6'd32, 6'd48}));
        chk("s0b0_twen", 32'({r_tw[0], r_tw[1], r_tw[2], r_tw[3]}), 32'b0111);
        chk("s0b0_twaddr", 32'({r_ta[1], r_ta[2], r_ta[3]}), 32'({6'd0, 6'd1, 6'd2}));
        chk("s0b0_phase", 32'({r_ph[0], r_ph[1], r_ph[2], r_ph[3]}), 32'b00011011);
        chk("s0b1_rd", 32'({r_ra[4], r_ra[5], r_ra[6], r_ra[7]}), 32'({6'd1, 6'd17, 6'd33, 6'd49}));
        chk("s0b1_twaddr", 32'({r_ta[5], r_ta[6], r_ta[7]}), 32'({6'd3, 6'd4, 6'd5}));
        chk("s0_last_rd", 32'(r_rd[63]), 1);
        cnt = 0;
        for (int c = 64; c < 70; c++) cnt += int'(r_rd[c]) + int'(r_tw[c]);
        chk("drain0_no_rd_tw", cnt, 0);
        chk("s1_first_rd", 32'({r_rd[70], r_stg[70], r_stg[69]}), 32'({1'b1, 2'd1, 2'd0}));
        chk("s1b5_rd", 32'({r_ra[90], r_ra[91], r_ra[92], r_ra[93]}), 32'({6'd17, 6'd21, 6'd25, 6'd29}));
        chk("s1b5_twaddr", 32'({r_ta[91], r_ta[92], r_ta[93]}), 32'({6'd12, 6'd13, 6'd14}));
        chk("s2b15_rd", 32'({r_ra[200], r_ra[201], r_ra[202], r_ra[203]}), 32'({6'd60, 6'd61, 6'd62, 6'd63}));
        chk("s2b15_twaddr", 32'({r_ta[201], r_ta[202], r_ta[203]}), 32'({6'd0, 6'd1, 6'd2}));
        chk("s2b15_stage", 32'(r_stg[200]), 2);

        // Abort together with start at stage 2, b=3.
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 152; i++) step();
        chk("pre_abort_pos", 32'({stage, rd_addr, rd_en}), 32'({2'd2, 6'd12, 1'b1}));
        abort = 1'b1;
        start = 1'b1;
        step();
        abort = 1'b0;
        start = 1'b0;
        chk_all_zero("abort");
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            cnt += int'(wr_en) + int'(done) + int'(busy);
        end
        chk("post_abort_quiet", cnt, 0);
        start = 1'b1;
        step();
        start = 1'b0;
        chk("restart_c0", 32'({busy, rd_en, rd_addr, stage, bf_phase, tw_en}), 32'({1'b1, 1'b1, 6'd0, 2'd0, 2'd0, 1'b0}));
        step();
        chk("restart_c1", 32'({rd_addr, tw_en, tw_addr}), 32'({6'd16, 1'b1, 6'd0}));

        // Reset mid-RUN at stage 1, b=5 (restart began at c=0, now at c=1).
        for (int i = 1; i < 90; i++) step();
        chk("pre_reset_pos", 32'({stage, rd_addr}), 32'({2'd1, 6'd17}));
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk_all_zero("mid_reset");
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            cnt += int'(wr_en) + int'(busy);
        end
        chk("post_reset_quiet", cnt, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
